univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg_if.sv | 43 ++++
 rtl/univ_shift_reg.sv | 121 ++++++++++++
 tb/tb_univ_shift_reg.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if
//   Groups the mode, serial and parallel data, automatic-shift control and
//   status signals of univ_shift_reg. The clock and reset stay plain ports.
//
//   S      mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   FILL   vacated bit: 00 serial in, 01 rotate, 10 replicate, 11 zero
//   DSR    serial input for right shifts
//   DSL    serial input for left shifts
//   D      parallel load data
//   START  request an automatic shift of CNT positions
//   CNT    shift count, sampled with START
//   Q      register contents
//   SOR    right-shift serial out (Q[WIDTH-1])
//   SOL    left-shift serial out (Q[0])
//   BUSY   automatic shift in progress
//   DONE   one-cycle completion pulse
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [1:0]       S;
    logic [1:0]       FILL;
    logic             DSR;
    logic             DSL;
    logic [WIDTH-1:0] D;
    logic             START;
    logic [CNT_W-1:0] CNT;
    logic [WIDTH-1:0] Q;
    logic             SOR;
    logic             SOL;
    logic             BUSY;
    logic             DONE;

    modport master (
        output S, FILL, DSR, DSL, D, START, CNT,
        input  Q, SOR, SOL, BUSY, DONE
    );

    modport slave (
        input  S, FILL, DSR, DSL, D, START, CNT,
        output Q, SOR, SOL, BUSY, DONE
    );
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   Universal shift register with selectable fill source and an automatic
//   multi-bit shift engine. "Right" moves bits toward the MSB (Q[i] <= Q[i-1]),
//   "left" moves bits toward the LSB.
//
//   CP   clock, rising edge
//   CR   asynchronous active-high reset
//   bus  univ_shift_reg_if.slave: S, FILL, DSR, DSL, D, START, CNT in;
//        Q, SOR, SOL, BUSY, DONE out
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CP,
    input  logic             CR,
    univ_shift_reg_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q, q_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic             dir_left, dir_left_n;
    logic [1:0]       fill_r, fill_n;
    logic             done, done_n;

    function automatic logic [WIDTH-1:0] shift_once(
        input logic [WIDTH-1:0] v,
        input logic             left,
        input logic [1:0]       fill,
        input logic             dsr,
        input logic             dsl
    );
        logic f;
        if (left) begin
            case (fill)
                2'b00:   f = dsl;
                2'b01:   f = v[0];
                2'b10:   f = v[WIDTH-1];
                default: f = 1'b0;
            endcase
            return {f, v[WIDTH-1:1]};
        end else begin
            case (fill)
                2'b00:   f = dsr;
                2'b01:   f = v[WIDTH-1];
                2'b10:   f = v[0];
                default: f = 1'b0;
            endcase
            return {v[WIDTH-2:0], f};
        end
    endfunction

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state    <= IDLE;
            q        <= '0;
            rem      <= '0;
            dir_left <= 1'b0;
            fill_r   <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            q        <= q_n;
            rem      <= rem_n;
            dir_left <= dir_left_n;
            fill_r   <= fill_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        q_n        = q;
        rem_n      = rem;
        dir_left_n = dir_left;
        fill_n     = fill_r;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.START && (bus.S == 2'b01 || bus.S == 2'b10) && bus.CNT != '0) begin
                    // The accepting edge already performs the first shift,
                    // so a count of one completes without entering RUN.
                    q_n        = shift_once(q, bus.S == 2'b10, bus.FILL, bus.DSR, bus.DSL);
                    dir_left_n = (bus.S == 2'b10);
                    fill_n     = bus.FILL;
                    rem_n      = bus.CNT - 1'b1;
                    if (bus.CNT == CNT_W'(1))
                        done_n = 1'b1;
                    else
                        state_n = RUN;
                end else begin
                    case (bus.S)
                        2'b01:   q_n = shift_once(q, 1'b0, bus.FILL, bus.DSR, bus.DSL);
                        2'b10:   q_n = shift_once(q, 1'b1, bus.FILL, bus.DSR, bus.DSL);
                        2'b11:   q_n = bus.D;
                        default: q_n = q;
                    endcase
                end
            end
            RUN: begin
                q_n   = shift_once(q, dir_left, fill_r, bus.DSR, bus.DSL);
                rem_n = rem - 1'b1;
                if (rem == CNT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.Q    = q;
    assign bus.SOR  = q[WIDTH-1];
    assign bus.SOL  = q[0];
    assign bus.BUSY = (state == RUN);
    assign bus.DONE = done;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    logic CP;
    logic CR;
    int   checks;
    int   errors;

    univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .CP  (CP),
        .CR  (CR),
        .bus (bus.slave)
    );

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        bus.START = 1'b0;
        bus.S     = 2'b11;
        bus.D     = v;
        step();
        chk("load", bus.Q, v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        CR        = 1'b1;
        bus.S     = 2'b00;
        bus.FILL  = 2'b00;
        bus.DSR   = 1'b0;
        bus.DSL   = 1'b0;
        bus.D     = 8'h00;
        bus.START = 1'b0;
        bus.CNT   = 4'd0;
        #12;
        CR = 1'b0;

        // Reset asserted mid-cycle clears everything without an edge
        load(8'h3C);
        #3; CR = 1'b1; #1;
        chk("rst_q", bus.Q, 8'h00);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_done", bus.DONE, 1'b0);
        #2; CR = 1'b0;

        // Load and hold
        load(8'hA5);
        bus.S = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold", bus.Q, 8'hA5);
        end

        // Single right shift with serial fill
        bus.S = 2'b01; bus.FILL = 2'b00; bus.DSR = 1'b1;
        step();
        chk("shr_q", bus.Q, 8'h4B);
        chk("shr_sor", bus.SOR, 1'b0);
        chk("shr_sol", bus.SOL, 1'b1);

        // Automatic left rotate by 3; RUN ignores S/D/START
        load(8'h81);
        bus.S = 2'b10; bus.FILL = 2'b01; bus.START = 1'b1; bus.CNT = 4'd3;
        step();
        chk("rot1_q", bus.Q, 8'hC0);
        chk("rot1_busy", bus.BUSY, 1'b1);
        chk("rot1_done", bus.DONE, 1'b0);
        bus.START = 1'b0; bus.S = 2'b11; bus.D = 8'hFF; bus.FILL = 2'b11;
        step();
        chk("rot2_q", bus.Q, 8'h60);
        chk("rot2_busy", bus.BUSY, 1'b1);
        chk("rot2_done", bus.DONE, 1'b0);
        step();
        chk("rot3_q", bus.Q, 8'h30);
        chk("rot3_busy", bus.BUSY, 1'b0);
        chk("rot3_done", bus.DONE, 1'b1);
        bus.S = 2'b00;
        step();
        chk("rot4_q", bus.Q, 8'h30);
        chk("rot4_done", bus.DONE, 1'b0);

        // Replicate fill on left shift
        load(8'h80);
        bus.S = 2'b10; bus.FILL = 2'b10;
        step();
        chk("rep1", bus.Q, 8'hC0);
        step();
        chk("rep2", bus.Q, 8'hE0);

        // Remaining fill modes
        load(8'h81);
        bus.S = 2'b01; bus.FILL = 2'b01;
        step(); chk("shr_rot", bus.Q, 8'h03);
        bus.FILL = 2'b11;
        step(); chk("shr_zero", bus.Q, 8'h06);
        bus.FILL = 2'b10;
        step(); chk("shr_rep", bus.Q, 8'h0C);
        bus.S = 2'b10; bus.FILL = 2'b00; bus.DSL = 1'b1;
        step(); chk("shl_ser", bus.Q, 8'h86);
        bus.FILL = 2'b11;
        step(); chk("shl_zero", bus.Q, 8'h43);

        // Reset aborts an automatic shift, no DONE
        load(8'hFF);
        bus.S = 2'b01; bus.FILL = 2'b11; bus.START = 1'b1; bus.CNT = 4'd5;
        step(); chk("ab1_q", bus.Q, 8'hFE);
        bus.START = 1'b0;
        step(); chk("ab2_q", bus.Q, 8'hFC);
        chk("ab2_busy", bus.BUSY, 1'b1);
        #3; CR = 1'b1; #1;
        chk("ab_q", bus.Q, 8'h00);
        chk("ab_busy", bus.BUSY, 1'b0);
        chk("ab_done", bus.DONE, 1'b0);
        #2; CR = 1'b0;
        bus.S = 2'b00;
        step();
        chk("ab_post_done", bus.DONE, 1'b0);
        chk("ab_post_busy", bus.BUSY, 1'b0);
        chk("ab_post_q", bus.Q, 8'h00);

        // START with CNT=0 acts as plain single shift
        load(8'h01);
        bus.S = 2'b01; bus.FILL = 2'b00; bus.DSR = 1'b0; bus.START = 1'b1; bus.CNT = 4'd0;
        step();
        chk("c0_q", bus.Q, 8'h02);
        chk("c0_busy", bus.BUSY, 1'b0);
        chk("c0_done", bus.DONE, 1'b0);
        bus.START = 1'b0; bus.S = 2'b00;
        step();
        chk("c0_done2", bus.DONE, 1'b0);

        // START with S=11 is ignored; load happens
        bus.START = 1'b1; bus.CNT = 4'd4; bus.S = 2'b11; bus.D = 8'h5A;
        step();
        chk("s11_q", bus.Q, 8'h5A);
        chk("s11_busy", bus.BUSY, 1'b0);

        // CNT=1 completes in IDLE with DONE next cycle
        load(8'h01);
        bus.S = 2'b10; bus.FILL = 2'b01; bus.START = 1'b1; bus.CNT = 4'd1;
        step();
        chk("c1_q", bus.Q, 8'h80);
        chk("c1_busy", bus.BUSY, 1'b0);
        chk("c1_done", bus.DONE, 1'b1);
        bus.START = 1'b0; bus.S = 2'b00;
        step();
        chk("c1_done2", bus.DONE, 1'b0);

        // CNT larger than WIDTH: right rotate by 10 wraps to 2 positions
        load(8'h01);
        bus.S = 2'b01; bus.FILL = 2'b01; bus.START = 1'b1; bus.CNT = 4'd10;
        step();
        bus.START = 1'b0; bus.S = 2'b00;
        for (int i = 1; i < 9; i++) begin
            chk("c10_busy", bus.BUSY, 1'b1);
            chk("c10_done", bus.DONE, 1'b0);
            step();
        end
        chk("c10_busy9", bus.BUSY, 1'b1);
        step();
        chk("c10_q", bus.Q, 8'h04);
        chk("c10_busy_end", bus.BUSY, 1'b0);
        chk("c10_done_end", bus.DONE, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
